// File: rtl/mantissa_subtractor_seq.sv
// ---------------------------------------------------------------------------
// mantissa_subtractor_seq
//
// Purpose:
//   Digit-serial magnitude subtractor for floating-point mantissas on the
//   effective-subtraction path. Computes |A-B| one DIGIT-bit slice per cycle
//   using a single small ripple slice. If the raw difference borrows out of
//   the top slice, a second digit-serial pass two's-complements the result.
//   Swap reports A<B for the sign logic. Zero reports exact cancellation.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   A          in   WIDTH  minuend mantissa
//   B          in   WIDTH  subtrahend mantissa
//   out_valid  out  1      result valid (high only in DONE)
//   out_ready  in   1      consumer takes result
//   Diff       out  WIDTH  |A-B|
//   Swap       out  1      1 when A<B (result was negated)
//   Zero       out  1      1 when Diff==0
//
// Timing:
//   From the accept edge to out_valid takes NDIG cycles when A>=B.
//   It takes 2*NDIG cycles when A<B.
//   Diff, Swap and Zero are loaded only on entry to DONE. They then hold
//   their values until the next result is loaded.
// ---------------------------------------------------------------------------
module mantissa_subtractor_seq #(
    parameter int WIDTH = 24,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Swap,
    output logic             Zero
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_NEG  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;      // operands shift right; the slice in use is always at bit 0
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;       // result shifts in from the top; it is aligned after NDIG steps
    logic [CW-1:0]    cnt;       // slice counter
    logic             cb;        // borrow during SUB, carry during NEG

    logic [DIGIT:0]   sub_slice;
    logic [DIGIT:0]   neg_slice;
    logic [DIGIT:0]   slice_out;
    logic [WIDTH-1:0] res_next;
    logic             last;

    // NOTE: every always_comb output gets a value on every path. This prevents latches.
    always_comb begin
        // Bit DIGIT of the (DIGIT+1)-bit difference is the borrow out of the slice.
        sub_slice = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, cb};
        // Negation pass: invert the low slice and add the incoming carry.
        neg_slice = {1'b0, ~res[DIGIT-1:0]} + {{DIGIT{1'b0}}, cb};
        slice_out = (state == S_NEG) ? neg_slice : sub_slice;
        res_next  = {slice_out[DIGIT-1:0], res[WIDTH-1:DIGIT]};
        last      = (cnt == CW'(NDIG - 1));
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments only. This way every
    // register samples its inputs from before the edge.
    // NOTE: the datapath registers are reset as well. Diff, Swap and Zero must
    // read 0 right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            cb    <= 1'b0;
            Diff  <= '0;
            Swap  <= 1'b0;
            Zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        cnt   <= '0;
                        cb    <= 1'b0;
                        state <= S_SUB;
                    end
                end
                S_SUB: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    res  <= res_next;
                    cb   <= slice_out[DIGIT];
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        cnt <= '0;
                        if (slice_out[DIGIT]) begin
                            // The raw difference is negative. The negation carry starts at 1.
                            cb    <= 1'b1;
                            state <= S_NEG;
                        end else begin
                            Diff  <= res_next;
                            Swap  <= 1'b0;
                            Zero  <= (res_next == '0);
                            state <= S_DONE;
                        end
                    end
                end
                S_NEG: begin
                    res <= res_next;
                    cb  <= slice_out[DIGIT];
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        cnt   <= '0;
                        Diff  <= res_next;
                        Swap  <= 1'b1;
                        Zero  <= (res_next == '0);
                        state <= S_DONE;
                    end
                end
                default: begin  // S_DONE
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mantissa_subtractor_seq.sv
// ---------------------------------------------------------------------------
// tb_mantissa_subtractor_seq
//
// Purpose:
//   Scoreboard bench for mantissa_subtractor_seq.
//   The driver issues operand pairs and queues the expected Diff, Swap,
//   Zero and latency for each one.
//   A monitor compares the DUT outputs when out_valid first rises.
//   Directed cases cover the following:
//     - ordinary subtraction and swapped subtraction
//     - cancellation
//     - full-length borrow ripple
//     - extreme operand values
//     - back-pressure
//     - reset during an operation
//   A short run of random pairs is checked against |A-B|.
// ---------------------------------------------------------------------------
module tb_mantissa_subtractor_seq;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Diff;
    logic         Swap;
    logic         Zero;

    typedef struct {
        logic [W-1:0] diff;
        logic         swap;
        logic         zero;
        int           acc;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen = 1'b0;

    mantissa_subtractor_seq #(.WIDTH(24), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Swap      (Swap),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares once per result, at the first negedge with out_valid high.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (!out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: Diff=0x%0h with empty scoreboard", Diff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff",    32'(Diff), 32'(e.diff));
                check("swap",    32'(Swap), 32'(e.swap));
                check("zero",    32'(Zero), 32'(e.zero));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Call this at a negedge. It waits (bounded) for in_ready and presents
    // the operands for one cycle.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic es, input logic ez,
                        input int el);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready stayed %0b, needed 1", in_ready);
            return;
        end
        A        = a;
        B        = b;
        in_valid = 1'b1;
        e.diff = ed;
        e.swap = es;
        e.zero = ez;
        e.acc  = cyc + 1;
        e.lat  = el;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, needed 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Directed vectors: A, B, expected Diff, expected Swap, expected Zero, expected latency.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         s;
        logic         z;
        int           l;
    } vec_t;

    vec_t vecs[8] = '{
        '{24'h000005, 24'h000003, 24'h000002, 1'b0, 1'b0,  6},
        '{24'h000003, 24'h000005, 24'h000002, 1'b1, 1'b0, 12},
        '{24'hABCDEF, 24'hABCDEF, 24'h000000, 1'b0, 1'b1,  6},
        '{24'h800000, 24'h7FFFFF, 24'h000001, 1'b0, 1'b0,  6},
        '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 12},
        '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1'b0, 1'b0,  6},
        '{24'h123456, 24'h654321, 24'h530ECB, 1'b1, 1'b0, 12},
        '{24'h100000, 24'h000001, 24'h0FFFFF, 1'b0, 1'b0,  6}
    };

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state: check this while reset is held and again after release.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_diff",      32'(Diff),      32'd0);
        check("rst_swap",      32'(Swap),      32'd0);
        check("rst_zero",      32'(Zero),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors.
        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].s, vecs[i].z, vecs[i].l);
        end
        wait_drain();

        // Back-pressure: hold the result in DONE while new operands are offered.
        out_ready = 1'b0;
        send(24'h00F000, 24'h000F00, 24'h00E100, 1'b0, 1'b0, 6);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
        end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        A        = 24'h111111;
        B        = 24'h222222;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_diff",      32'(Diff),      32'h00E100);
            check("bp_swap",      32'(Swap),      32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        // The block is back in IDLE. The result is held and the offered operands are still pending.
        check("bp_idle_in_ready", 32'(in_ready),  32'd1);
        check("bp_idle_valid",    32'(out_valid), 32'd0);
        check("bp_idle_diff",     32'(Diff),      32'h00E100);
        begin
            exp_t e;
            e.diff = 24'h111111;
            e.swap = 1'b1;
            e.zero = 1'b0;
            e.acc  = cyc + 1;
            e.lat  = 12;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();

        // Reset in the middle of the negation pass.
        check("pre_rst_diff", 32'(Diff), 32'h111111);
        A        = 24'h000003;
        B        = 24'h000005;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midneg_out_valid", 32'(out_valid), 32'd0);
        check("midneg_diff",      32'(Diff),      32'd0);
        check("midneg_swap",      32'(Swap),      32'd0);
        check("midneg_zero",      32'(Zero),      32'd0);
        check("midneg_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(24'h000010, 24'h000001, 24'h00000F, 1'b0, 1'b0, 6);
        wait_drain();

        // Random pairs against a behavioural |A-B|.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = (i % 10 == 0) ? ra : W'($urandom);
            if (ra >= rb) send(ra, rb, ra - rb, 1'b0, (ra == rb), 6);
            else          send(ra, rb, rb - ra, 1'b1, 1'b0, 12);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
